// File: rtl/hex_debug_display_if.sv
// Board-pin and core-side signal bundle for the DE2 hex/key debug block.
// The master drives pins and the debug value. The slave returns debounced keys and segments.
interface hex_debug_display_if #(
   parameter int NUM_KEYS   = 4,
   parameter int NUM_DIGITS = 8,
   parameter int DATA_W     = 32
);
   logic [NUM_KEYS-1:0]     key_n;
   logic [DATA_W-1:0]       value_in;
   logic                    value_valid;
   logic                    blank_lz;
   logic [NUM_KEYS-1:0]     key_level;
   logic [NUM_KEYS-1:0]     key_press;
   logic                    frozen;
   logic [7*NUM_DIGITS-1:0] hex_out;

   modport master (
      output key_n, value_in, value_valid, blank_lz,
      input  key_level, key_press, frozen, hex_out
   );

   modport slave (
      input  key_n, value_in, value_valid, blank_lz,
      output key_level, key_press, frozen, hex_out
   );
endinterface

// File: rtl/hex_debug_display.sv
// Debounces pushbuttons, captures a freezable debug value and drives seven-segment hex digits.
// Latency: key_level follows a clean pin edge after 2+DEBOUNCE_CYCLES edges; value_valid reaches hex_out after 2 edges.
// No backpressure: value_valid is sampled every cycle and is dropped while frozen.
module hex_debug_display #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int NUM_DIGITS      = 8,
   parameter int DATA_W          = 32
) (
   input  logic               clk,
   input  logic               rst,
   hex_debug_display_if.slave dbg
);
   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0]     sync1, sync2;
   logic [NUM_KEYS-1:0]     sample;
   logic [CNT_W-1:0]        cnt [NUM_KEYS];
   logic [NUM_KEYS-1:0]     key_level_q, key_level_d, key_press_q;
   logic                    frozen_q;
   logic [DATA_W-1:0]       disp;
   logic [7*NUM_DIGITS-1:0] hex_q, hex_nxt;
   logic                    lz_run;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // Buttons are asynchronous to clk; two flops before anything looks at them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= dbg.key_n;
         sync2 <= sync1;
      end
   end

   assign sample = ~sync2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
         key_level_q <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (sample[i] == key_level_q[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               key_level_q[i] <= sample[i];
               cnt[i]         <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Capture uses frozen before this edge's toggle, so a freezing press still takes the value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_level_d <= '0;
         key_press_q <= '0;
         frozen_q    <= 1'b0;
         disp        <= '0;
         hex_q       <= '1;
      end else begin
         key_level_d <= key_level_q;
         key_press_q <= key_level_q & ~key_level_d;
         frozen_q    <= frozen_q ^ key_press_q[0];
         if (dbg.value_valid && !frozen_q) disp <= dbg.value_in;
         hex_q <= hex_nxt;
      end
   end

   // Scan from the top digit; blanking stops at the first nonzero nibble or at digit 0.
   always_comb begin
      lz_run  = dbg.blank_lz;
      hex_nxt = '1;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         if (disp[4*d +: 4] != 4'h0 || d == 0) lz_run = 1'b0;
         hex_nxt[7*d +: 7] = lz_run ? 7'h7F : seg7(disp[4*d +: 4]);
      end
   end

   assign dbg.key_level = key_level_q;
   assign dbg.key_press = key_press_q;
   assign dbg.frozen    = frozen_q;
   assign dbg.hex_out   = hex_q;
endmodule

// File: tb/tb_hex_debug_display.sv
// Self-checking bench for hex_debug_display: directed plan cases plus randomized traffic
// against a history-based reference model.
module tb_hex_debug_display;
   localparam int NK = 4;
   localparam int DB = 4;
   localparam int ND = 8;
   localparam int DW = 32;

   localparam logic [6:0] SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hex_debug_display_if #(.NUM_KEYS(NK), .NUM_DIGITS(ND), .DATA_W(DW)) dbg ();

   hex_debug_display #(
      .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .NUM_DIGITS(ND), .DATA_W(DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .dbg (dbg)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: pin history, last DB pressed samples, visible outputs.
   logic [NK-1:0]   pin_q [$];
   logic [NK-1:0]   smp_q [$];
   logic [NK-1:0]   m_level, m_press, m_rose;
   logic            m_frozen;
   logic [DW-1:0]   m_disp;
   logic [ND*7-1:0] m_hex;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [ND*7-1:0] model_hex(input logic [DW-1:0] v, input logic blz);
      logic [ND*7-1:0] r;
      int msd;
      msd = 0;
      for (int d = 0; d < ND; d++) if (v[4*d +: 4] != 4'h0) msd = d;
      for (int d = 0; d < ND; d++)
         r[7*d +: 7] = (blz && d > msd) ? 7'h7F : SEG[v[4*d +: 4]];
      return r;
   endfunction

   task automatic model_reset();
      pin_q.delete();
      pin_q.push_back('1);
      pin_q.push_back('1);
      smp_q.delete();
      repeat (DB) smp_q.push_back('0);
      m_level  = '0;
      m_press  = '0;
      m_rose   = '0;
      m_frozen = 1'b0;
      m_disp   = '0;
      m_hex    = '1;
   endtask

   // One clock edge: a key level flips once its last DB pressed samples all disagree with it.
   task automatic model_edge();
      logic [NK-1:0]   s, rose;
      logic [ND*7-1:0] nh;
      int              differ;
      nh = model_hex(m_disp, dbg.blank_lz);
      if (dbg.value_valid && !m_frozen) m_disp = dbg.value_in;
      if (m_press[0]) m_frozen = !m_frozen;
      m_press = m_rose;
      s = ~pin_q.pop_front();
      pin_q.push_back(dbg.key_n);
      void'(smp_q.pop_front());
      smp_q.push_back(s);
      rose = '0;
      for (int i = 0; i < NK; i++) begin
         differ = 0;
         foreach (smp_q[j]) if (smp_q[j][i] != m_level[i]) differ++;
         if (differ == DB) begin
            rose[i]    = !m_level[i];
            m_level[i] = !m_level[i];
         end
      end
      m_rose = rose;
      m_hex  = nh;
   endtask

   task automatic compare_all();
      check("key_level", dbg.key_level, m_level);
      check("key_press", dbg.key_press, m_press);
      check("frozen",    dbg.frozen,    m_frozen);
      check("hex_out",   dbg.hex_out,   m_hex);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   // Called at a negedge; reset asserts mid-cycle and outputs must clear without a clock edge.
   task automatic async_reset();
      #2 rst = 1'b0;
      #1 model_reset();
      compare_all();
      check("rst_level", dbg.key_level, 0);
      check("rst_frozen", dbg.frozen, 0);
      check("rst_hex", dbg.hex_out, {ND*7{1'b1}});
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      dbg.key_n       = '1;
      dbg.value_in    = '0;
      dbg.value_valid = 1'b0;
      dbg.blank_lz    = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      check("init_hex_dark", dbg.hex_out, {ND*7{1'b1}});
      rst = 1'b1;
      tick();
      check("init_hex_zero", dbg.hex_out, {ND{7'b1000000}});

      // Clean press and release of key 1.
      dbg.key_n = 4'b1101;
      repeat (5) tick();
      check("k1_not_yet", dbg.key_level[1], 0);
      tick();
      check("k1_level", dbg.key_level[1], 1);
      check("k1_no_early_pulse", dbg.key_press, 0);
      tick();
      check("k1_press", dbg.key_press, 4'b0010);
      tick();
      check("k1_press_one_cycle", dbg.key_press, 0);
      dbg.key_n = 4'hF;
      repeat (5) tick();
      check("k1_rel_not_yet", dbg.key_level[1], 1);
      tick();
      check("k1_released", dbg.key_level[1], 0);
      tick();
      check("k1_no_release_pulse", dbg.key_press, 0);

      // Bouncing key 2, then a steady hold.
      dbg.key_n = 4'b1011;
      repeat (2) tick();
      dbg.key_n = 4'hF;
      tick();
      dbg.key_n = 4'b1011;
      repeat (2) tick();
      check("k2_bounce_rejected", dbg.key_level[2], 0);
      repeat (3) tick();
      check("k2_hold_not_yet", dbg.key_level[2], 0);
      tick();
      check("k2_level", dbg.key_level[2], 1);
      tick();
      check("k2_single_press", dbg.key_press, 4'b0100);
      dbg.key_n = 4'hF;
      repeat (8) tick();

      // Capture and decode, with and without leading-zero blanking.
      dbg.value_in    = 32'h1234ABCF;
      dbg.value_valid = 1'b1;
      tick();
      dbg.value_valid = 1'b0;
      tick();
      check("hex_1234abcf", dbg.hex_out, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                          7'b0001000, 7'b0000011, 7'b1000110, 7'b0001110});
      dbg.value_in    = 32'h000000F0;
      dbg.blank_lz    = 1'b1;
      dbg.value_valid = 1'b1;
      tick();
      dbg.value_valid = 1'b0;
      tick();
      check("hex_f0_blanked", dbg.hex_out, {{6{7'h7F}}, 7'b0001110, 7'b1000000});

      // Freeze via key 0, ignored capture, unfreeze, capture again.
      dbg.key_n = 4'b1110;
      repeat (7) tick();
      check("k0_press", dbg.key_press, 4'b0001);
      tick();
      check("frozen_set", dbg.frozen, 1);
      dbg.key_n       = 4'hF;
      dbg.value_in    = 32'hDEADBEEF;
      dbg.value_valid = 1'b1;
      tick();
      dbg.value_valid = 1'b0;
      repeat (2) tick();
      check("frozen_hold_display", dbg.hex_out, {{6{7'h7F}}, 7'b0001110, 7'b1000000});
      repeat (6) tick();
      dbg.key_n = 4'b1110;
      repeat (8) tick();
      check("frozen_clear", dbg.frozen, 0);
      dbg.key_n       = 4'hF;
      dbg.value_in    = 32'h0000BEEF;
      dbg.value_valid = 1'b1;
      tick();
      dbg.value_valid = 1'b0;
      tick();
      check("hex_beef", dbg.hex_out, {{4{7'h7F}}, 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});
      repeat (6) tick();

      // Reset while frozen and mid-debounce of key 3.
      dbg.key_n = 4'b1110;
      repeat (8) tick();
      check("pre_rst_frozen", dbg.frozen, 1);
      dbg.key_n = 4'b0110;
      repeat (3) tick();
      async_reset();
      repeat (5) tick();
      check("k3_after_rst_not_yet", dbg.key_level[3], 0);
      tick();
      check("k3_after_rst_level", dbg.key_level[3], 1);
      dbg.key_n = 4'hF;
      repeat (8) tick();

      // Randomized traffic checked every cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NK; i++)
            if ($urandom_range(0, 9) == 0) dbg.key_n[i] = ~dbg.key_n[i];
         dbg.value_valid = ($urandom_range(0, 3) == 0);
         dbg.value_in    = $urandom >> (4 * $urandom_range(0, 8));
         if ($urandom_range(0, 63) == 0) dbg.blank_lz = ~dbg.blank_lz;
         if ($urandom_range(0, 999) == 0) async_reset();
         else tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hex_debug_display.md
Name: hex_debug_display

Overview:
- Parametrised board-level debug I/O block for the DE2 wrapper. It sits between the board pins (KEY, HEX0..HEX7) and the processor core.
- Synchronises and debounces NUM_KEYS active-low pushbuttons and emits clean press levels and single-cycle press pulses.
- Captures a debug value from the core, with a freeze mode toggled by key 0.
- Drives NUM_DIGITS seven-segment digits in hex, with optional leading-zero blanking.

Parameters:
- NUM_KEYS, 4, number of pushbutton inputs debounced (min 1).
- DEBOUNCE_CYCLES, 1000000, consecutive stable synced samples required before a level change is accepted (20 ms at 50 MHz; min 2).
- NUM_DIGITS, 8, number of seven-segment digits driven (1..8).
- DATA_W, 32, width of the debug value; must equal 4*NUM_DIGITS.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous, active-low reset.
- key_n  in  NUM_KEYS  raw pushbuttons, active-low (0 = pressed), asynchronous to clk.
- value_in  in  DATA_W  debug value from the core.
- value_valid  in  1  capture strobe for value_in.
- blank_lz  in  1  1 = blank leading zero digits.
- key_level  out  NUM_KEYS  debounced level, 1 = pressed.
- key_press  out  NUM_KEYS  one-cycle pulse on each debounced press (released->pressed).
- frozen  out  1  1 = display capture frozen.
- hex_out  out  7*NUM_DIGITS  active-low segments; digit d occupies bits [7d+6:7d]; bit 0 = seg a ... bit 6 = seg g.

Behaviour:
- Reset (rst=0, async):
  - key_level=0, key_press=0, frozen=0.
  - Sync flops reset to 1 (released); debounce counters=0; display register=0.
  - hex_out = all ones (all segments off).
- Synchronisation: each key_n bit passes through 2 flops, then is inverted to form a sample s (1 = pressed).
- Debounce, per key, independent:
  - s==key_level: counter cleared.
  - Otherwise counter increments.
  - When counter==DEBOUNCE_CYCLES-1 and s still differs: key_level<=s and counter cleared.
  - Any sample equal to key_level before then clears the counter (glitch rejected).
  - Latency from a clean pin edge to key_level change: 2 + DEBOUNCE_CYCLES cycles.
- key_press[i]: high exactly one cycle, the cycle after key_level[i] goes 0->1. No pulse on release.
- Freeze:
  - key_press[0] toggles frozen on the next edge.
  - The other key_press bits have no internal effect; they are outputs for the core.
- Capture:
  - Display register <= value_in on an edge where value_valid=1 and frozen=0 (value of frozen before any same-cycle toggle).
  - If value_valid coincides with a key_press[0] pulse that sets frozen, the value is still captured.
  - While frozen=1, value_valid is ignored.
- Decode:
  - hex_out is registered, updated every cycle from the display register and blank_lz.
  - value_valid at edge N -> register at N+1 -> hex_out reflects it after edge N+2.
  - Encoding (gfedcba, active-low):
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (blank_lz=1):
  - Digits above the most significant nonzero nibble output 1111111.
  - Digit 0 is never blanked (value 0 shows "0").
  - With blank_lz=0, all digits are shown.
- Reset mid-debounce or while frozen: all state returns to reset values; nothing is retained.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4, NUM_DIGITS=8):
- Reset release, key_n=4'hF, blank_lz=0 -> hex_out all ones after reset; one edge later all eight digits show 1000000; key_level=0, frozen=0.
- key_n[1] driven 0 and held -> key_level[1]=1 exactly 6 edges later; key_press[1] high for exactly 1 cycle, one cycle later. Releasing -> key_level[1]=0 after 6 edges with no pulse.
- key_n[2] low 2 cycles, high 1 cycle, low 2 cycles (bounce) -> key_level[2] stays 0; then holding low 6 edges -> single press pulse.
- value_in=32'h1234ABCF, value_valid 1 cycle, blank_lz=0 -> 2 edges later, digit7..digit0 = 1,2,3,4,A,b,C,F encodings. Then value_in=32'h000000F0 with blank_lz=1 -> digits 7..2 = 1111111, digit1=0001110, digit0=1000000.
- Press key 0 (frozen=1), then value_valid with 32'hDEADBEEF -> display unchanged. Press key 0 again -> frozen=0; next valid captures.
- Assert rst low mid-debounce of key 3 and while frozen -> all outputs at reset values immediately (async). After release, the key must again be held 6 edges to register.
